// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg: opcodes, condition-code bit indices and state types for alu_mc |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD          = 4'h0;
  localparam logic [3:0] OP_SUB          = 4'h1;
  localparam logic [3:0] OP_AND          = 4'h2;
  localparam logic [3:0] OP_OR           = 4'h3;
  localparam logic [3:0] OP_XOR          = 4'h4;
  localparam logic [3:0] OP_NOT          = 4'h5;
  localparam logic [3:0] OP_MULT         = 4'h6;
  localparam logic [3:0] OP_LESS_THAN    = 4'h7;
  localparam logic [3:0] OP_GREATER_THAN = 4'h8;
  localparam logic [3:0] OP_EQUAL        = 4'h9;
  // DIV/REM occupy encodings the combinational ALU left unused
  localparam logic [3:0] OP_DIV          = 4'hA;
  localparam logic [3:0] OP_REM          = 4'hB;

  localparam int CC_DIV0   = 3;
  localparam int CC_BORROW = 2;
  localparam int CC_OVF    = 1;
  localparam int CC_CMP    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ITER_MUL = 2'd0,
    ITER_DIV = 2'd1,
    ITER_REM = 2'd2
  } iter_mode_e;

endpackage

`default_nettype wire

// File: rtl/alu_mc_if.sv
// +----------------------------------------------------------------------+
// | alu_mc_if: operand/result handshake bundle for alu_mc                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_mc_if #(
  parameter int WIDTH = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_cc;

  modport master (
    output flush, in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, alu_out, alu_cc
  );

  modport slave (
    input  flush, in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, alu_out, alu_cc
  );
endinterface

`default_nettype wire

// File: rtl/alu_iter.sv
// +----------------------------------------------------------------------+
// | alu_iter: shared shift datapath, shift-add multiply and (ALU_DIV_EN)  |
// | restoring unsigned divide, one iteration per clock. Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  iter_mode_e       mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // acc: product or partial remainder; x: multiplier or dividend/quotient; y: multiplicand or divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_acc;

`ifdef ALU_DIV_EN
  iter_mode_e       mode_q, mode_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
`endif

  always_comb begin
    mul_acc = x_q[0] ? (acc_q + y_q) : acc_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    result  = mul_acc;
`ifdef ALU_DIV_EN
    mode_d   = mode_q;
    rem_sh   = {acc_q, x_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, y_q};
    q_bit    = ~rem_diff[WIDTH];
    if (mode_q == ITER_DIV) begin
      result = {x_q[WIDTH-2:0], q_bit};
    end else if (mode_q == ITER_REM) begin
      result = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end
`endif

    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      acc_d = '0;
      x_d   = a;
      y_d   = b;
      cnt_d = CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
      mode_d = mode;
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_DIV_EN
      if (mode_q != ITER_MUL) begin
        acc_d = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], q_bit};
      end else
`endif
      begin
        acc_d = mul_acc;
        x_d   = x_q >> 1;
        y_d   = y_q << 1;
      end
    end

    // result above is the value the final iteration produces, valid when done
    done = (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
`ifdef ALU_DIV_EN
      mode_q <= ITER_MUL;
`endif
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
`ifdef ALU_DIV_EN
      mode_q <= mode_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// +----------------------------------------------------------------------+
// | alu_mc: multi-cycle handshaked ALU; ALU_DIV_EN enables DIV/REM.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       cc_q, cc_d;

  logic             xfer_in;
  logic             is_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] single_out;
  logic [3:0]       single_cc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

`ifdef ALU_DIV_EN
  iter_mode_e       iter_mode;
  logic             b_zero;
`endif

  assign bus.in_ready  = ~bus.flush &
                         ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_out   = out_q;
  assign bus.alu_cc    = cc_q;
  assign xfer_in       = bus.in_valid & bus.in_ready;

  always_comb begin
    single_out    = '0;
    single_cc     = '0;
    sum           = bus.a + bus.b;
    {borrow, diff} = {1'b0, bus.a} - {1'b0, bus.b};
    is_iter       = (bus.alu_op == OP_MULT);
`ifdef ALU_DIV_EN
    b_zero    = (bus.b == '0);
    iter_mode = ITER_MUL;
    if (bus.alu_op == OP_DIV) iter_mode = ITER_DIV;
    if (bus.alu_op == OP_REM) iter_mode = ITER_REM;
    // divide by zero bypasses the datapath and completes in one cycle
    if (((bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM)) && !b_zero) is_iter = 1'b1;
`endif

    case (bus.alu_op)
      OP_ADD: begin
        single_out        = sum;
        single_cc[CC_OVF] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        single_out           = diff;
        single_cc[CC_BORROW] = borrow;
        single_cc[CC_OVF]    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:          single_out = bus.a & bus.b;
      OP_OR:           single_out = bus.a | bus.b;
      OP_XOR:          single_out = bus.a ^ bus.b;
      OP_NOT:          single_out = ~bus.a;
      OP_LESS_THAN:    single_cc[CC_CMP] = ($signed(bus.a) < $signed(bus.b));
      OP_GREATER_THAN: single_cc[CC_CMP] = ($signed(bus.a) > $signed(bus.b));
      OP_EQUAL:        single_cc[CC_CMP] = (bus.a == bus.b);
`ifdef ALU_DIV_EN
      OP_DIV: begin
        single_out         = '1;
        single_cc[CC_DIV0] = 1'b1;
      end
      OP_REM: begin
        single_out         = bus.a;
        single_cc[CC_DIV0] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cc_d       = cc_q;
    iter_start = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (xfer_in) begin
            if (is_iter) begin
              iter_start = 1'b1;
              state_d    = BUSY;
            end else begin
              out_d   = single_out;
              cc_d    = single_cc;
              state_d = DONE;
            end
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (iter_done) begin
            out_d   = iter_result;
            cc_d    = '0;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cc_q    <= cc_d;
    end
  end

  alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (bus.flush),
    .start  (iter_start),
`ifdef ALU_DIV_EN
    .mode   (iter_mode),
`endif
    .a      (bus.a),
    .b      (bus.b),
    .done   (iter_done),
    .result (iter_result)
  );

endmodule

`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised-width ALU for the execute stage, replacing the purely combinational ALU when iterative multiply or divide is needed. It accepts one operation per valid/ready handshake, completes single-cycle ops in one clock, runs MULT/DIV/REM on a shared iterative shift datapath, and holds each result plus condition codes until downstream accepts it.

## Interface
- WIDTH, 32: operand/result width, must be ≥ 4
- CNT_W, $clog2(WIDTH+1): iteration counter width, derived, not overridden
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any in-flight or held op
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept this cycle
- a, b  in  WIDTH  operands
- alu_op  in  4  opcode, existing set plus DIV and REM
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts result
- alu_out  out  WIDTH  result
- alu_cc  out  4  [3]=div-by-zero, [2]=borrow (SUB), [1]=signed overflow (ADD/SUB), [0]=compare true

## Operation
- States: IDLE, BUSY, DONE. Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready); out_valid = (state==DONE).
- IDLE/DONE on transfer in: single-cycle op (ADD, SUB, AND, OR, XOR, NOT, compares, undefined) → result/cc registered, go DONE; MULT, DIV, REM → load operands, counter=WIDTH, go BUSY.
- DONE on transfer out with no transfer in → IDLE.
- BUSY: one iteration per clock, counter decrements; at counter 1→0 result registered, go DONE.
- ADD/SUB/logic/compares: same semantics and cc rules as the combinational ALU, generalised to WIDTH (sign bit = WIDTH-1); compares signed, alu_out=0.
- MULT: shift-add, unsigned, low WIDTH bits of product; cc=0.
- DIV/REM: restoring, unsigned; DIV→quotient, REM→remainder. b==0: no BUSY, result in 1 cycle, DIV=all ones, REM=a, cc[3]=1.
- Undefined opcode: alu_out=0, cc=0, 1-cycle latency.
- flush (highest priority after reset): next state IDLE, out_valid low next cycle, in-flight result discarded; in_ready forced low during flush cycle.
- Operand registers captured at transfer in; a/b/alu_op may change afterwards.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, alu_out=0, alu_cc=0, counter=0.
- Latency transfer-in to out_valid: 1 cycle single-cycle ops and divide-by-zero; WIDTH+1 cycles MULT/DIV/REM.
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high.
- alu_out/alu_cc stable while out_valid & ~out_ready.
- No combinational path from in_valid/a/b/alu_op to any output; in_ready depends combinationally on out_ready only.
- Reset asserted mid-BUSY: immediate return to reset values; no partial result ever visible.

## Configuration
- ALU_DIV_EN defined: DIV/REM use iterative datapath as above.
- Undefined: divide hardware removed; DIV/REM treated as undefined opcodes (1 cycle, alu_out=0, alu_cc=0); MULT unaffected.

## Structure
- Shared package alu_pkg: opcode constants including DIV/REM (assigned from unused 4-bit encodings), state enum, alu_cc bit index constants.
- Sub-module alu_iter: shift-add/restoring-subtract datapath with start, mode, done; alu_mc owns FSM, handshake, single-cycle ops.

## Test plan
- Reset mid-MULT (a=7, b=9, rst_n low at cycle 5) → all outputs at reset values; next MULT 7×9 → alu_out=63 after 33 cycles (WIDTH=32).
- ADD 0x7FFFFFFF+1 → alu_out=0x80000000, cc=0b0010, out_valid 1 cycle after transfer; SUB 3−5 → 0xFFFFFFFE, cc=0b0100.
- DIV 100/7 → 14, REM 100/7 → 2, each 33 cycles; DIV 5/0 → 0xFFFFFFFF, cc=0b1000 in 1 cycle; without ALU_DIV_EN → 0, cc=0.
- Back-to-back XOR stream with out_ready=1 → one result per cycle; drop out_ready for 3 cycles → result held stable, in_ready low.
- flush asserted during BUSY of DIV → out_valid never rises for it; following AND 0xF0&0x3C → 0x30.
- LESS_THAN a=0x80000000, b=1 → cc[0]=1; GREATER_THAN same operands → cc[0]=0; alu_out=0 both.
